// File: rtl/frame_buf_pp.sv
// rtl/frame_buf_pp.sv - two-bank ping-pong frame buffer; repeats the shown frame when no new frame is ready
module frame_buf_pp #(
    parameter int DATA_W = 24,
    parameter int H_RES  = 4,
    parameter int V_RES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_rdy,
    output logic              wr_eof,
    input  logic              rd_en_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              rd_sof,
    output logic              rd_eof,
    output logic              rd_empty,
    output logic              frame_repeat,
    output logic              overflow
);
    localparam int DEPTH  = H_RES * V_RES;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_AW = $clog2(2 * DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [2*DEPTH];

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              pending_q, pending_d;
    logic              rd_empty_q, rd_empty_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_sof_q, rd_sof_d;
    logic              rd_eof_q, rd_eof_d;
    logic              wr_eof_q, wr_eof_d;
    logic              frame_repeat_q, frame_repeat_d;
    logic              overflow_q, overflow_d;

    logic              rd_bank;
    logic              wr_acc, rd_acc, wr_last, rd_last, swap;
    logic [MEM_AW-1:0] wr_idx, rd_idx;

    // The two banks are always distinct, so the read bank is just the other one.
    assign rd_bank = ~wr_bank_q;
    assign wr_idx  = MEM_AW'(wr_addr_q) + (wr_bank_q ? MEM_AW'(DEPTH) : MEM_AW'(0));
    assign rd_idx  = MEM_AW'(rd_addr_q) + (rd_bank ? MEM_AW'(DEPTH) : MEM_AW'(0));

    always_comb begin
        wr_acc  = wr_en_in && !pending_q;
        rd_acc  = rd_en_in && !rd_empty_q;
        wr_last = wr_acc && (wr_addr_q == LAST_ADDR);
        rd_last = rd_acc && (rd_addr_q == LAST_ADDR);
        // Swap only on a registered pending frame: first frame, or at a read frame end.
        swap    = pending_q && (rd_empty_q || rd_last);

        wr_addr_d = wr_addr_q;
        if (wr_acc) wr_addr_d = wr_last ? '0 : wr_addr_q + ADDR_W'(1);
        rd_addr_d = rd_addr_q;
        if (rd_acc) rd_addr_d = rd_last ? '0 : rd_addr_q + ADDR_W'(1);

        wr_bank_d      = swap ? ~wr_bank_q : wr_bank_q;
        pending_d      = swap ? 1'b0 : (wr_last ? 1'b1 : pending_q);
        rd_empty_d     = rd_empty_q && !swap;
        data_out_d     = rd_acc ? mem[rd_idx] : data_out_q;
        rd_valid_d     = rd_acc;
        rd_sof_d       = rd_acc && (rd_addr_q == '0);
        rd_eof_d       = rd_last;
        wr_eof_d       = wr_last;
        frame_repeat_d = rd_last && !pending_q;
        overflow_d     = overflow_q || (wr_en_in && pending_q);
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_idx] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            wr_bank_q      <= 1'b0;
            pending_q      <= 1'b0;
            rd_empty_q     <= 1'b1;
            data_out_q     <= '0;
            rd_valid_q     <= 1'b0;
            rd_sof_q       <= 1'b0;
            rd_eof_q       <= 1'b0;
            wr_eof_q       <= 1'b0;
            frame_repeat_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            wr_bank_q      <= wr_bank_d;
            pending_q      <= pending_d;
            rd_empty_q     <= rd_empty_d;
            data_out_q     <= data_out_d;
            rd_valid_q     <= rd_valid_d;
            rd_sof_q       <= rd_sof_d;
            rd_eof_q       <= rd_eof_d;
            wr_eof_q       <= wr_eof_d;
            frame_repeat_q <= frame_repeat_d;
            overflow_q     <= overflow_d;
        end
    end

    assign wr_rdy       = !pending_q;
    assign wr_eof       = wr_eof_q;
    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign rd_sof       = rd_sof_q;
    assign rd_eof       = rd_eof_q;
    assign rd_empty     = rd_empty_q;
    assign frame_repeat = frame_repeat_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_frame_buf_pp.sv
// tb/tb_frame_buf_pp.sv - randomized and directed bench for frame_buf_pp against a frame-level model
module tb_frame_buf_pp;
    localparam int DEPTH = 8;

    logic        clk, reset, wr_en_in, rd_en_in;
    logic [23:0] data_in, data_out;
    logic        wr_rdy, wr_eof, rd_valid, rd_sof, rd_eof, rd_empty, frame_repeat, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: a frame under construction, an optional finished frame, and the shown frame.
    logic [23:0] m_wq[$];
    logic [23:0] m_pend_frame[DEPTH];
    logic [23:0] m_shown[DEPTH];
    logic        m_pend, m_shown_ok;
    int          m_rptr;
    logic [23:0] e_dout;
    logic        e_valid, e_sof, e_eof, e_weof, e_frep, e_ovf;

    frame_buf_pp dut (
        .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .data_in(data_in), .wr_rdy(wr_rdy),
        .wr_eof(wr_eof), .rd_en_in(rd_en_in), .data_out(data_out), .rd_valid(rd_valid),
        .rd_sof(rd_sof), .rd_eof(rd_eof), .rd_empty(rd_empty), .frame_repeat(frame_repeat),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b1; wr_en_in = 1'b1; rd_en_in = 1'b1; data_in = 24'h5a5a5a;
        @(posedge clk); #1;
        reset = 1'b0; wr_en_in = 1'b0; rd_en_in = 1'b0; data_in = '0;
        m_wq.delete(); m_pend = 1'b0; m_shown_ok = 1'b0; m_rptr = 0;
        e_dout = '0; e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
        e_weof = 1'b0; e_frep = 1'b0; e_ovf = 1'b0;
    endtask

    task automatic step(input logic we, input logic [23:0] d, input logic re);
        logic wacc, racc, rlast, swp;
        wr_en_in = we; data_in = d; rd_en_in = re;
        wacc  = we && !m_pend;
        racc  = re && m_shown_ok;
        rlast = racc && (m_rptr == DEPTH - 1);
        e_valid = racc;
        e_sof   = racc && (m_rptr == 0);
        e_eof   = rlast;
        if (racc) e_dout = m_shown[m_rptr];
        e_frep = rlast && !m_pend;
        e_weof = wacc && (m_wq.size() == DEPTH - 1);
        if (we && m_pend) e_ovf = 1'b1;
        swp = m_pend && (!m_shown_ok || rlast);
        if (racc) m_rptr = rlast ? 0 : m_rptr + 1;
        if (swp) begin
            m_shown = m_pend_frame; m_pend = 1'b0; m_shown_ok = 1'b1;
        end
        if (wacc) begin
            m_wq.push_back(d);
            if (m_wq.size() == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) m_pend_frame[i] = m_wq[i];
                m_wq.delete();
                m_pend = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_data_out: got %0h expected 0", data_out); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_sof !== 1'b0 || rd_eof !== 1'b0) begin n_fail++; $display("FAIL reset_sof_eof: got %b%b expected 00", rd_sof, rd_eof); end
        n_checks++; if (wr_eof !== 1'b0 || frame_repeat !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", wr_eof, frame_repeat); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rd_empty: got %b expected 1", rd_empty); end
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b expected 1", wr_rdy); end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 24'h0, 1'b1);
            n_checks++;
            if (rd_valid !== 1'b0 || rd_empty !== 1'b1 || data_out !== 24'h0) begin
                n_fail++;
                $display("FAIL empty_read: got valid=%b empty=%b dout=%0h expected 0 1 0", rd_valid, rd_empty, data_out);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [23:0] got[$];
        int weof_cnt, first_c, last_c, sof_ok, eof_ok;
        do_reset();
        weof_cnt = 0; first_c = -1; last_c = -1; sof_ok = 0; eof_ok = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 24'(i), 1'b0);
            if (wr_eof) weof_cnt++;
        end
        for (int c = 0; c < 20 && got.size() < DEPTH; c++) begin
            step(1'b0, 24'h0, 1'b1);
            if (wr_eof) weof_cnt++;
            n_checks++;
            if (rd_valid !== e_valid || data_out !== e_dout) begin
                n_fail++;
                $display("FAIL single_model: got v=%b d=%0h expected v=%b d=%0h", rd_valid, data_out, e_valid, e_dout);
            end
            if (rd_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got.push_back(data_out);
                if (rd_sof && data_out == 24'd1) sof_ok++;
                if (rd_eof && data_out == 24'd8) eof_ok++;
            end
        end
        n_checks++; if (weof_cnt != 1) begin n_fail++; $display("FAIL single_wr_eof: got %0d pulses expected 1", weof_cnt); end
        n_checks++; if (rd_empty !== 1'b0) begin n_fail++; $display("FAIL single_rd_empty: got %b expected 0", rd_empty); end
        n_checks++; if (got.size() != DEPTH || last_c - first_c != DEPTH - 1) begin n_fail++; $display("FAIL single_consecutive: got %0d words over %0d cycles expected 8 over 8", got.size(), last_c - first_c + 1); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 24'(i + 1)) begin n_fail++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, got[i], i + 1); end
        end
        n_checks++; if (sof_ok != 1 || eof_ok != 1) begin n_fail++; $display("FAIL single_sof_eof: got sof=%0d eof=%0d expected 1 1", sof_ok, eof_ok); end
    endtask

    task automatic test_overflow();
        logic [23:0] got[$];
        logic        we;
        logic [23:0] d;
        int          nw;
        bit          sent17;
        do_reset();
        sent17 = 0;
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 24'(i), 1'b0);
        step(1'b0, 24'h0, 1'b0);
        nw = 9;
        for (int c = 0; c < 80 && got.size() < 2 * DEPTH; c++) begin
            we = 1'b0; d = '0;
            if (nw <= 16 && wr_rdy) begin
                we = 1'b1; d = 24'(nw); nw++;
            end else if (nw > 16 && !sent17) begin
                n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_wr_rdy: got %b expected 0", wr_rdy); end
                we = 1'b1; d = 24'd17; sent17 = 1;
            end
            step(we, d, c >= 2);
            if (rd_valid) got.push_back(data_out);
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        n_checks++; if (got.size() != 2 * DEPTH) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 24'(i + 1)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, got[i], i + 1); end
        end
    endtask

    task automatic test_repeat();
        logic [23:0] got[$];
        int rep_cnt, rep_bad;
        do_reset();
        rep_cnt = 0; rep_bad = 0;
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 24'(i), 1'b0);
        for (int c = 0; c < 40 && got.size() < 2 * DEPTH; c++) begin
            step(1'b0, 24'h0, 1'b1);
            if (rd_valid) got.push_back(data_out);
            if (frame_repeat) begin
                rep_cnt++;
                if (!(rd_eof && rd_valid && data_out == 24'd8)) rep_bad++;
            end
        end
        n_checks++; if (rep_cnt != 2 || rep_bad != 0) begin n_fail++; $display("FAIL repeat_pulse: got %0d pulses (%0d misplaced) expected 2 (0)", rep_cnt, rep_bad); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 24'((i % DEPTH) + 1)) begin n_fail++; $display("FAIL repeat_data[%0d]: got %0h expected %0h", i, got[i], (i % DEPTH) + 1); end
        end
        n_checks++; if (got.size() != 2 * DEPTH) begin n_fail++; $display("FAIL repeat_count: got %0d expected 16", got.size()); end
    endtask

    task automatic test_same_edge();
        logic [23:0] got[$];
        logic [23:0] exp_q[$];
        int rep_cnt, first_rep_at;
        do_reset();
        rep_cnt = 0; first_rep_at = -1;
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 24'(i), 1'b0);
        step(1'b0, 24'h0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) exp_q.push_back(24'(i));
        for (int i = 1; i <= DEPTH; i++) exp_q.push_back(24'(i));
        for (int i = 9; i <= 16; i++) exp_q.push_back(24'(i));
        for (int c = 0; c < 60 && got.size() < 3 * DEPTH; c++) begin
            if (c < DEPTH) step(1'b1, 24'(9 + c), 1'b1);
            else           step(1'b0, 24'h0, 1'b1);
            if (rd_valid) got.push_back(data_out);
            if (frame_repeat) begin
                rep_cnt++;
                if (first_rep_at < 0) first_rep_at = got.size();
            end
            n_checks++;
            if (data_out !== e_dout || frame_repeat !== e_frep) begin
                n_fail++;
                $display("FAIL same_edge_model: got d=%0h rep=%b expected d=%0h rep=%b", data_out, frame_repeat, e_dout, e_frep);
            end
        end
        n_checks++; if (first_rep_at != DEPTH || rep_cnt != 2) begin n_fail++; $display("FAIL same_edge_repeat: got first=%0d cnt=%0d expected 8 2", first_rep_at, rep_cnt); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL same_edge_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL same_edge_data[%0d]: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] got[$];
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 24'(i), 1'b0);
        step(1'b0, 24'h0, 1'b0);
        for (int c = 1; c <= 5; c++) step(1'b1, 24'(8'h10 + c), 1'b1);
        do_reset();
        n_checks++;
        if (data_out !== 24'h0 || rd_valid !== 1'b0 || rd_sof !== 1'b0 || rd_eof !== 1'b0 || wr_eof !== 1'b0 ||
            frame_repeat !== 1'b0 || overflow !== 1'b0 || rd_empty !== 1'b1 || wr_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got d=%0h v=%b s=%b e=%b we=%b fr=%b ov=%b emp=%b rdy=%b expected 0 0 0 0 0 0 0 1 1",
                     data_out, rd_valid, rd_sof, rd_eof, wr_eof, frame_repeat, overflow, rd_empty, wr_rdy);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 24'(8'h21 + i), 1'b0);
        for (int c = 0; c < 20 && got.size() < DEPTH; c++) begin
            step(1'b0, 24'h0, 1'b1);
            if (rd_valid) got.push_back(data_out);
        end
        n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL mid_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 24'(8'h21 + i)) begin n_fail++; $display("FAIL mid_data[%0d]: got %0h expected %0h", i, got[i], 8'h21 + i); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 6, 24'($urandom), $urandom_range(0, 9) < 7);
            n_checks++; if (data_out !== e_dout) begin n_fail++; $display("FAIL rnd_data_out @%0d: got %0h expected %0h", c, data_out, e_dout); end
            n_checks++; if (rd_valid !== e_valid || rd_sof !== e_sof || rd_eof !== e_eof) begin n_fail++; $display("FAIL rnd_rd_flags @%0d: got %b%b%b expected %b%b%b", c, rd_valid, rd_sof, rd_eof, e_valid, e_sof, e_eof); end
            n_checks++; if (wr_eof !== e_weof || frame_repeat !== e_frep) begin n_fail++; $display("FAIL rnd_pulses @%0d: got %b%b expected %b%b", c, wr_eof, frame_repeat, e_weof, e_frep); end
            n_checks++; if (overflow !== e_ovf) begin n_fail++; $display("FAIL rnd_overflow @%0d: got %b expected %b", c, overflow, e_ovf); end
            n_checks++; if (wr_rdy !== !m_pend || rd_empty !== !m_shown_ok) begin n_fail++; $display("FAIL rnd_status @%0d: got rdy=%b empty=%b expected %b %b", c, wr_rdy, rd_empty, !m_pend, !m_shown_ok); end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en_in = 1'b0; rd_en_in = 1'b0; data_in = '0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_repeat();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_buf_pp.md
FRAME_BUF_PP -- requirements
Module: frame_buf_pp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, pixel width in bits.
REQ-002 The block SHALL have parameter H_RES, default 4, pixels per line.
REQ-003 The block SHALL have parameter V_RES, default 2, lines per frame; DEPTH = H_RES*V_RES, ADDR_W = clog2(DEPTH), minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port wr_en_in, input, 1 bit, write request for one pixel.
REQ-007 The block SHALL have port data_in, input, DATA_W bits, write pixel.
REQ-008 The block SHALL have port wr_rdy, output, 1 bit, write bank free; a write is accepted when wr_en_in && wr_rdy.
REQ-009 The block SHALL have port wr_eof, output, 1 bit, one-cycle pulse on the cycle after the last pixel of a frame is accepted.
REQ-010 The block SHALL have port rd_en_in, input, 1 bit, read request for one pixel.
REQ-011 The block SHALL have port data_out, output, DATA_W bits, registered read pixel.
REQ-012 The block SHALL have port rd_valid, output, 1 bit, data_out valid this cycle.
REQ-013 The block SHALL have port rd_sof, output, 1 bit, high with rd_valid on pixel 0 of a frame.
REQ-014 The block SHALL have port rd_eof, output, 1 bit, high with rd_valid on pixel DEPTH-1.
REQ-015 The block SHALL have port rd_empty, output, 1 bit, high while no complete frame has been shown since reset.
REQ-016 The block SHALL have port frame_repeat, output, 1 bit, one-cycle pulse when a frame end occurs with no new frame pending.
REQ-017 The block SHALL have port overflow, output, 1 bit, sticky: wr_en_in seen while wr_rdy low.

Function
REQ-018 The block SHALL hold 2*DEPTH words in two banks (ping-pong): a write bank (wr_bank) and a read bank (rd_bank), always distinct.
REQ-019 Each accepted write SHALL store data_in at mem[wr_bank][wr_addr] and increment wr_addr; on acceptance at wr_addr=DEPTH-1, wr_addr wraps to 0, pending is set and wr_eof pulses the next cycle.
REQ-020 wr_rdy SHALL equal !pending; writes while pending are dropped, memory is unchanged, and overflow is set until reset.
REQ-021 A read SHALL be accepted when rd_en_in && !rd_empty; it registers mem[rd_bank][rd_addr] to data_out with rd_valid=1 one cycle later (latency 1), then increments rd_addr.
REQ-022 rd_en_in while rd_empty SHALL be ignored: rd_valid=0, and data_out holds its value.
REQ-023 When rd_valid=0, data_out SHALL hold its last value, and rd_sof and rd_eof SHALL be 0.
REQ-024 On read acceptance at rd_addr=DEPTH-1, rd_addr SHALL wrap to 0, using the registered pending value at that edge:
  - pending=1: swap wr_bank/rd_bank, clear pending.
  - pending=0: keep rd_bank (frame repeats), pulse frame_repeat the next cycle.
REQ-025 Initial swap: when rd_empty=1 and pending=1, the block SHALL swap banks, clear pending and clear rd_empty on the next edge.
REQ-026 Write completion on the same edge as a read frame end SHALL NOT swap on that edge; the new frame waits for the next read frame end.
REQ-027 wr_rdy SHALL rise the cycle after a swap; no write is accepted in the swap cycle.
REQ-028 Reads and writes in the same cycle SHALL proceed independently, because the banks differ.

Reset
REQ-029 On reset, these SHALL be cleared on the next edge, and reset dominates any simultaneous read, write or swap:
  - wr_addr=0, rd_addr=0, wr_bank=0, rd_bank=1, pending=0.
  - rd_empty=1, wr_rdy=1.
  - data_out=0, rd_valid=0, rd_sof=0, rd_eof=0, wr_eof=0, frame_repeat=0, overflow=0.
REQ-030 Memory contents SHALL NOT be cleared by reset; a frame partially written at reset is discarded.

Verification (H_RES=4, V_RES=2, DEPTH=8)
REQ-031 Bench: reset, rd_en_in=1 for 5 cycles -> rd_valid=0, rd_empty=1, data_out=0 throughout.
REQ-032 Bench: write 1..8 consecutively, then hold rd_en_in=1 -> wr_eof one pulse, rd_empty falls, data_out=1..8 on consecutive cycles, rd_sof with 1, rd_eof with 8.
REQ-033 Bench: write 1..8, then 9..16 while reading -> second frame pending, wr_rdy=0; 17 is written with wr_rdy low -> overflow=1 and 17 is never read; first read pass yields 1..8, second pass yields 9..16.
REQ-034 Bench: one frame 1..8 written, reads continue with no new writes -> frame_repeat pulses after the pixel-8 read, and the next pass yields 1..8 again.
REQ-035 Bench: last write and the pixel-8 read occur on the same edge -> no swap on that edge, frame_repeat pulses, and the new frame is shown on the following pass.
REQ-036 Bench: reset asserted after 5 of 8 writes and mid-read -> all outputs at reset values; a subsequent full frame 0x21..0x28 reads back exactly.
